// File: rtl/bcd_pkg.sv
// Shared constants, display FSM state encoding and the digit-to-ASCII helper
// for the BCD stopwatch.
package bcd_pkg;

  localparam logic [3:0] BCD_NINE   = 4'd9;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  typedef enum logic [0:0] {
    DISP_IDLE = 1'b0,
    DISP_SEND = 1'b1
  } disp_state_t;

  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] digit);
    return ASCII_ZERO + {4'd0, digit};
  endfunction

endpackage

// File: rtl/bcd_incrementer.sv
// One decade of the BCD count: next value and carry for a single nibble.
// Purely combinational; the stopwatch top owns the digit registers.
module bcd_incrementer
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       en,
  output logic [3:0] next_digit,
  output logic       carry
);

  // Values above nine are treated like nine so an upset nibble heals on its next step.
  always_comb begin
    next_digit = digit;
    carry      = 1'b0;
    if (en) begin
      if (digit >= BCD_NINE) begin
        next_digit = 4'd0;
        carry      = 1'b1;
      end else begin
        next_digit = digit + 4'd1;
        carry      = 1'b0;
      end
    end else begin
      next_digit = digit;
      carry      = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_stopwatch.sv
// BCD stopwatch: prescaled decimal counter plus an ASCII frame streamer for an LCD writer.
// Define BCD_STOPWATCH_LAP_EN to add the lap input and the frozen lap display.
module bcd_stopwatch
  import bcd_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int DIGITS   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                clear,
`ifdef BCD_STOPWATCH_LAP_EN
  input  logic                lap,
`endif
  output logic [4*DIGITS-1:0] count_bcd,
  output logic                overflow,
  output logic [7:0]          char_data,
  output logic [2:0]          char_index,
  output logic                char_valid,
  input  logic                char_ready
);

  localparam int              PW           = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESCALE_MAX = PW'(TICK_DIV - 1);
  localparam logic [2:0]      LAST_INDEX   = 3'(DIGITS - 1);

  logic [PW-1:0]       prescaler;
  logic                tick;
  logic [4*DIGITS-1:0] next_count;
  logic [DIGITS:0]     carry_chain;
  logic [4*DIGITS-1:0] display_src;
  logic [4*DIGITS-1:0] snapshot;
  logic                change;
  logic                dirty;
  disp_state_t         state;
  logic                accept;
  logic                frame_done;
  logic                start;

  function automatic logic [7:0] digit_ascii(input logic [4*DIGITS-1:0] value,
                                             input logic [2:0]          index);
    logic [4*DIGITS-1:0] shifted;
    shifted = value >> (4 * (DIGITS - 1 - int'(index)));
    return bcd_to_ascii(shifted[3:0]);
  endfunction

  // Prescaler counts run-enabled cycles; tick is registered so the count moves one cycle later.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      prescaler <= '0;
      tick      <= 1'b0;
    end else if (run) begin
      if (prescaler == PRESCALE_MAX) begin
        prescaler <= '0;
        tick      <= 1'b1;
      end else begin
        prescaler <= prescaler + PW'(1);
        tick      <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  assign carry_chain[0] = tick;

  for (genvar n = 0; n < DIGITS; n++) begin : g_digit
    bcd_incrementer u_inc (
      .digit      (count_bcd[4*n +: 4]),
      .en         (carry_chain[n]),
      .next_digit (next_count[4*n +: 4]),
      .carry      (carry_chain[n+1])
    );
  end

  // Live count register; a carry out of the top digit is the all-9s wrap.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_bcd <= '0;
      overflow  <= 1'b0;
    end else begin
      count_bcd <= next_count;
      overflow  <= carry_chain[DIGITS];
    end
  end

`ifdef BCD_STOPWATCH_LAP_EN
  logic                frozen;
  logic [4*DIGITS-1:0] lap_count;

  // Each lap pulse toggles the freeze; entering it captures the live count.
  always_ff @(posedge clk) begin
    if (reset) begin
      frozen    <= 1'b0;
      lap_count <= '0;
    end else if (lap) begin
      frozen <= ~frozen;
      if (!frozen) begin
        lap_count <= count_bcd;
      end else begin
        lap_count <= lap_count;
      end
    end else begin
      frozen    <= frozen;
      lap_count <= lap_count;
    end
  end

  assign display_src = frozen ? lap_count : count_bcd;
  assign change      = clear | lap | (tick & ~frozen);
`else
  assign display_src = count_bcd;
  assign change      = clear | tick;
`endif

  assign accept     = char_valid & char_ready;
  assign frame_done = accept & (char_index == LAST_INDEX);
  // A pending change restarts straight from the last accepted character, without an idle gap.
  assign start      = dirty & ((state == DISP_IDLE) | frame_done);

  // Display FSM: snapshot the source, then stream its digits MSD first as ASCII.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= DISP_IDLE;
      dirty      <= 1'b1;
      snapshot   <= '0;
      char_valid <= 1'b0;
      char_index <= 3'd0;
      char_data  <= ASCII_ZERO;
    end else begin
      if (change) begin
        dirty <= 1'b1;
      end else if (start) begin
        dirty <= 1'b0;
      end else begin
        dirty <= dirty;
      end

      if (start) begin
        state      <= DISP_SEND;
        snapshot   <= display_src;
        char_valid <= 1'b1;
        char_index <= 3'd0;
        char_data  <= digit_ascii(display_src, 3'd0);
      end else if (frame_done) begin
        state      <= DISP_IDLE;
        char_valid <= 1'b0;
        char_index <= 3'd0;
      end else if (accept) begin
        char_index <= char_index + 3'd1;
        char_data  <= digit_ascii(snapshot, char_index + 3'd1);
      end else begin
        state      <= state;
        char_valid <= char_valid;
      end
    end
  end

endmodule
